// File: rtl/alu_types.sv
// alu_types: ALU operation encoding shared by the ALU and its controllers.
package alu_types;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_control_t;
endpackage

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: states, datapath select encodings and RV32I opcodes for the controller.
package multicycle_controller_pkg;
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_ERROR
  } controller_state_t;
  typedef enum logic [1:0] {SRC_A_PC, SRC_A_OLD_PC, SRC_A_REG} alu_src_a_t;
  typedef enum logic [1:0] {SRC_B_REG, SRC_B_IMM, SRC_B_FOUR} alu_src_b_t;
  typedef enum logic [1:0] {RES_ALU_OUT, RES_MEM_DATA, RES_ALU_RESULT} result_src_t;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps funct3/funct7b5 of R/I-type instructions to an ALU operation.
module alu_decoder
  import alu_types::*;
(
  input  logic         is_r_type,
  input  logic [2:0]   funct3,
  input  logic         funct7b5,
  output alu_control_t alu_control
);
  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      3'b000: alu_control = (is_r_type && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLTU;
      3'b100: alu_control = ALU_XOR;
      3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequences each RV32I instruction over 3-5 cycles and drives the datapath controls.
module multicycle_controller
  import alu_types::*;
  import multicycle_controller_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic         funct7b5,
  input  logic         zero,
  output alu_control_t alu_control,
  output alu_src_a_t   alu_src_a,
  output alu_src_b_t   alu_src_b,
  output result_src_t  result_src,
  output imm_src_t     imm_src,
  output logic         adr_src,
  output logic         ir_write,
  output logic         pc_write,
  output logic         reg_write,
  output logic         mem_write,
  output logic         error
);
  controller_state_t state, next_state;
  alu_control_t decoded;
  alu_decoder u_alu_decoder (
    .is_r_type  (op == OP_R),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_control(decoded)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_RESET;
    else state <= next_state;
  assign imm_src = (op == OP_STORE) ? IMM_S : (op == OP_BRANCH) ? IMM_B : (op == OP_JAL) ? IMM_J : IMM_I;
  always_comb begin
    next_state  = S_FETCH;
    alu_control = ALU_ADD;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_REG;
    result_src  = RES_ALU_OUT;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    error       = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_RESULT;
        pc_write   = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_BRANCH:         next_state = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ERROR;
          OP_JAL:            next_state = S_JAL;
          default:           next_state = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRC_A_REG;
        alu_src_b  = SRC_B_IMM;
        next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = SRC_A_REG;
        alu_control = decoded;
        next_state  = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = SRC_A_REG;
        alu_src_b   = SRC_B_IMM;
        alu_control = decoded;
        next_state  = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = SRC_A_REG;
        alu_control = ALU_SUB;
        pc_write    = zero ^ funct3[0];
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
      S_ERROR: begin
        error      = 1'b1;
        next_state = S_ERROR;
      end
      default: next_state = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table, random and corner-case checks of the controller against a per-step reference.
module tb_multicycle_controller;
  import alu_types::*;
  import multicycle_controller_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, zero;
  alu_control_t alu_control;
  alu_src_a_t alu_src_a;
  alu_src_b_t alu_src_b;
  result_src_t result_src;
  imm_src_t imm_src;
  logic adr_src, ir_write, pc_write, reg_write, mem_write, error;
  int checks = 0;
  int errors = 0;
  logic [17:0] dw;
  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write), .error(error)
  );
  always #5 clk = ~clk;
  assign dw = {alu_control, alu_src_a, alu_src_b, result_src, imm_src,
               adr_src, ir_write, pc_write, reg_write, mem_write, error};
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // Packs {alu, src_a, src_b, result_src, imm_src, adr, ir, pc, reg, mem, error}.
  function automatic logic [17:0] mk(input int alu, input int a, input int b, input int rs, input int imm,
                                     input int adr, input int ir, input int pc, input int rw, input int mw, input int err);
    return {4'(alu), 2'(a), 2'(b), 2'(rs), 2'(imm), 1'(adr), 1'(ir), 1'(pc), 1'(rw), 1'(mw), 1'(err)};
  endfunction
  function automatic int ref_imm(input logic [6:0] o);
    return (o == 7'h23) ? 1 : (o == 7'h63) ? 2 : (o == 7'h6f) ? 3 : 0;
  endfunction
  // ALU encoding order: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  function automatic int ref_alu(input bit r, input int f3, input bit f7);
    if (f3 == 0) return (r && f7) ? 1 : 0;
    if (f3 < 5) return f3 + 1;
    if (f3 == 5) return f7 ? 7 : 6;
    return f3 + 2;
  endfunction
  // Cycles from FETCH through the last state; 0 means illegal.
  function automatic int ref_lat(input logic [6:0] o, input int f3);
    case (o)
      7'h03: return 5;
      7'h23, 7'h33, 7'h13, 7'h6f: return 4;
      7'h63: return (f3 < 2) ? 3 : 0;
      default: return 0;
    endcase
  endfunction
  function automatic logic [17:0] ref_word(input logic [6:0] o, input int f3, input bit f7, input bit z, input int s);
    int imm = ref_imm(o);
    if (s == 0) return mk(0, 0, 2, 2, imm, 0, 1, 1, 0, 0, 0);
    if (s == 1) return mk(0, 1, 1, 0, imm, 0, 0, 0, 0, 0, 0);
    if (ref_lat(o, f3) == 0) return mk(0, 0, 0, 0, imm, 0, 0, 0, 0, 0, 1);
    if (o == 7'h03 || o == 7'h23) begin
      if (s == 2) return mk(0, 2, 1, 0, imm, 0, 0, 0, 0, 0, 0);
      if (o == 7'h23) return mk(0, 0, 0, 0, imm, 1, 0, 0, 0, 1, 0);
      if (s == 3) return mk(0, 0, 0, 0, imm, 1, 0, 0, 0, 0, 0);
      return mk(0, 0, 0, 1, imm, 0, 0, 0, 1, 0, 0);
    end
    if (o == 7'h63) return mk(1, 2, 0, 0, imm, 0, 0, int'(z ^ f3[0]), 0, 0, 0);
    if (s == 3) return mk(0, 0, 0, 0, imm, 0, 0, 0, 1, 0, 0);
    if (o == 7'h33) return mk(ref_alu(1'b1, f3, f7), 2, 0, 0, imm, 0, 0, 0, 0, 0, 0);
    if (o == 7'h13) return mk(ref_alu(1'b0, f3, f7), 2, 1, 0, imm, 0, 0, 0, 0, 0, 0);
    return mk(0, 1, 2, 0, imm, 0, 0, 1, 0, 0, 0);
  endfunction
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input bit f7, input int n, input int zfix,
                           input bit fetch_next, output logic [3:0] alu2, output logic pc2);
    op = o; funct3 = f3; funct7b5 = f7;
    alu2 = 4'hx; pc2 = 1'bx;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      zero = (zfix < 0) ? 1'($urandom % 2) : 1'(zfix);
      #1;
      check($sformatf("step%0d_op%h_f%0d", s, o, f3), 32'(dw), 32'(ref_word(o, int'(f3), f7, zero, s)));
      if (s == 2) begin alu2 = alu_control; pc2 = pc_write; end
    end
    if (fetch_next) begin
      @(posedge clk); #1;
      check("fetch_after", 32'(ir_write), 32'd1);
    end
  endtask
  task automatic abort_reset(input string name);
    #2 rst = 1'b0;
    #1 check({name, "_async"}, 32'(dw), 32'(mk(0, 0, 0, 0, ref_imm(op), 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    check({name, "_held"}, 32'(dw), 32'(mk(0, 0, 0, 0, ref_imm(op), 0, 0, 0, 0, 0, 0)));
    @(negedge clk) rst = 1'b1;
  endtask
  typedef struct {
    logic [6:0] op; logic [2:0] f3; bit f7; int z; int cycles; logic [3:0] alu; logic pc;
  } vec_t;
  vec_t vecs[13];
  logic [3:0] a2;
  logic p2;
  initial begin
    vecs[0]  = '{7'h03, 3'd2, 1'b0, 0, 5, 4'd0, 1'b0};
    vecs[1]  = '{7'h23, 3'd2, 1'b0, 0, 4, 4'd0, 1'b0};
    vecs[2]  = '{7'h33, 3'd0, 1'b1, 0, 4, 4'd1, 1'b0};
    vecs[3]  = '{7'h33, 3'd5, 1'b0, 0, 4, 4'd6, 1'b0};
    vecs[4]  = '{7'h33, 3'd7, 1'b0, 0, 4, 4'd9, 1'b0};
    vecs[5]  = '{7'h13, 3'd0, 1'b1, 0, 4, 4'd0, 1'b0};
    vecs[6]  = '{7'h13, 3'd5, 1'b1, 0, 4, 4'd7, 1'b0};
    vecs[7]  = '{7'h13, 3'd2, 1'b0, 0, 4, 4'd3, 1'b0};
    vecs[8]  = '{7'h63, 3'd1, 1'b0, 1, 3, 4'd1, 1'b0};
    vecs[9]  = '{7'h63, 3'd1, 1'b0, 0, 3, 4'd1, 1'b1};
    vecs[10] = '{7'h63, 3'd0, 1'b0, 1, 3, 4'd1, 1'b1};
    vecs[11] = '{7'h6f, 3'd0, 1'b0, 0, 4, 4'd0, 1'b1};
    vecs[12] = '{7'h33, 3'd6, 1'b1, 0, 4, 4'd8, 1'b0};
    op = 7'h33; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_word", 32'(dw), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    end
    rst = 1'b1;
    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].cycles, vecs[i].z, 1'b1, a2, p2);
      check($sformatf("vec%0d_alu", i), 32'(a2), 32'(vecs[i].alu));
      check($sformatf("vec%0d_pcw", i), 32'(p2), 32'(vecs[i].pc));
    end
    for (int k = 0; k < 150; k++) begin
      logic [6:0] o;
      logic [2:0] f;
      case ($urandom % 6)
        0: o = 7'h03;
        1: o = 7'h23;
        2: o = 7'h33;
        3: o = 7'h13;
        4: o = 7'h63;
        default: o = 7'h6f;
      endcase
      f = (o == 7'h63) ? 3'($urandom % 2) : 3'($urandom);
      run_instr(o, f, 1'($urandom), ref_lat(o, int'(f)), -1, 1'b1, a2, p2);
    end
    run_instr(7'h7f, 3'd0, 1'b0, 12, -1, 1'b0, a2, p2);
    abort_reset("illegal_op");
    run_instr(7'h63, 3'd2, 1'b0, 6, -1, 1'b0, a2, p2);
    abort_reset("illegal_branch");
    run_instr(7'h23, 3'd3, 1'b0, 4, -1, 1'b0, a2, p2);
    check("memwrite_before_abort", 32'(mem_write), 32'd1);
    abort_reset("memwrite_abort");
    run_instr(7'h03, 3'd2, 1'b0, 5, -1, 1'b1, a2, p2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy control FSM for the multi-cycle RV32I core; sits directly upstream of alu.
- Decodes opcode/funct fields from the instruction register and sequences each instruction over 3-5 cycles.
- Drives the ALU operation select (alu_control_t), ALU operand muxes, PC/IR/register/memory write strobes and result-source select.
- Consumes the ALU's zero flag for branch resolution.

Parameters:
- none; datapath width is fixed at 32 by alu_types.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag, current cycle
- alu_control  out  alu_control_t  ALU operation select
- alu_src_a  out  2  0=PC, 1=OLD_PC, 2=REG_A
- alu_src_b  out  2  0=REG_B, 1=IMM, 2=CONST_4
- result_src  out  2  0=ALU_OUT (registered), 1=MEM_DATA, 2=ALU_RESULT (combinational)
- imm_src  out  2  0=I, 1=S, 2=B, 3=J
- adr_src  out  1  0=PC, 1=RESULT
- ir_write  out  1  latch instruction and OLD_PC
- pc_write  out  1  load PC from RESULT
- reg_write  out  1  register-file write enable
- mem_write  out  1  data-memory write enable
- error  out  1  sticky illegal-instruction flag

Behaviour:
- Reset: rst low forces state RESET immediately, regardless of clock. In RESET every strobe (ir_write, pc_write, reg_write, mem_write, error) is 0; all selects are 0; alu_control is ALU_ADD.
- The first rising edge after rst deasserts moves RESET to FETCH.
- Reset asserted mid-instruction aborts it. No strobe may be high while rst is low.
- Default in every state: all strobes 0 and selects 0 unless listed below. alu_control is ALU_ADD unless listed.
- imm_src is combinational from op in every state:
  - store gives S; branch gives B; jal gives J; otherwise I.
- States and actions:
  - FETCH: adr_src=0, ir_write=1, src_a=PC, src_b=CONST_4, ADD, result_src=ALU_RESULT, pc_write=1. Next: DECODE.
  - DECODE: src_a=OLD_PC, src_b=IMM, ADD (precomputes branch/jal target). Next by op:
    - 0000011 (lw) or 0100011 (sw) go to MEMADR.
    - 0110011 goes to EXEC_R; 0010011 goes to EXEC_I.
    - 1100011 goes to BRANCH only if funct3 is 000 or 001.
    - 1101111 goes to JAL.
    - Anything else goes to ERROR.
  - MEMADR: src_a=REG_A, src_b=IMM, ADD. Next: MEMREAD if op=lw, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=ALU_OUT. Next: MEMWB.
  - MEMWB: result_src=MEM_DATA, reg_write=1. Next: FETCH.
  - MEMWRITE: adr_src=1, result_src=ALU_OUT, mem_write=1. Next: FETCH.
  - EXEC_R: src_a=REG_A, src_b=REG_B, alu_control=decoded. Next: ALUWB.
  - EXEC_I: src_a=REG_A, src_b=IMM, alu_control=decoded. Next: ALUWB.
  - ALUWB: result_src=ALU_OUT, reg_write=1. Next: FETCH.
  - BRANCH: src_a=REG_A, src_b=REG_B, SUB, result_src=ALU_OUT. pc_write = zero XOR funct3[0] (Mealy; beq/bne). Next: FETCH.
  - JAL: src_a=OLD_PC, src_b=CONST_4, ADD, result_src=ALU_OUT, pc_write=1. Next: ALUWB, which writes the link address.
  - ERROR: error=1 and all strobes 0. The controller stays here until reset.
- ALU decode (funct3, then funct7b5):
  - 000: R-type with funct7b5=1 gives SUB, else ADD. I-type always gives ADD.
  - 001 gives SLL; 010 gives SLT; 011 gives SLTU; 100 gives XOR.
  - 101: funct7b5=1 gives SRA, else SRL.
  - 110 gives OR; 111 gives AND.
- Latencies in cycles, FETCH inclusive: lw 5, sw 4, R/I 4, branch 3, jal 4.

Decomposition:
- The core package holds:
  - the controller_state_t enum;
  - the alu_src_a_t, alu_src_b_t, result_src_t and imm_src_t enums with the encodings above;
  - the opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL.
- alu_control_t is reused from alu_types.
- One sub-module: alu_decoder, combinational mapping (is_r_type, funct3, funct7b5) to alu_control_t.

Test Plan:
- Hold rst low for 3 cycles, then release. Required: all strobes 0 during reset; FETCH on the first edge after release (ir_write=1, pc_write=1, ADD, src_b=CONST_4).
- op=0000011 (lw). Required: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; reg_write=1 only in MEMWB, with result_src=1.
- op=0110011, funct3=000, funct7b5=1. Required: alu_control=ALU_SUB in EXEC_R. Repeat with funct3=101, funct7b5=0: ALU_SRL. With funct3=111: ALU_AND.
- op=1100011, funct3=001 (bne). With zero=1 in BRANCH: pc_write=0. With zero=0: pc_write=1. With funct3=000 and zero=1: pc_write=1.
- op=1101111 (jal). Required: JAL state with pc_write=1 and result_src=0, then ALUWB with reg_write=1, then FETCH.
- op=1111111. Required: ERROR after DECODE, error=1, no strobes for 10 cycles. Pulling rst low clears error asynchronously.
- Assert rst in MEMWRITE. Required: mem_write drops without waiting for a clock edge, and the FSM returns to RESET.
